csi2_packetizer: RTL and testbench



---
 rtl/csi2_packetizer.sv | 204 ++++++++++++++++++++
 tb/tb_csi2_packetizer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_packetizer.sv
// CSI-2 packetizer: wraps the 8-byte-per-clock pixel stream into FS/FE short packets and
// one long packet per active line (ECC header, payload, CRC-16 footer) behind a 2-deep delay line.
module csi2_packetizer #(
  parameter int HACT          = 16,
  parameter int VC            = 0,
  parameter int FRAME_NUM_MAX = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [63:0] i_pixel_data,
  input  logic        i_pixel_valid,
  input  logic [5:0]  i_data_type,
  output logic [63:0] o_data,
  output logic [7:0]  o_byte_en,
  output logic        o_valid,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_err
);

  localparam logic [15:0] LP_WC       = 16'(HACT * 2);
  localparam logic [15:0] LP_WORDS    = 16'(HACT / 4);
  localparam logic [15:0] LP_FNUM_MAX = 16'(FRAME_NUM_MAX);
  localparam logic [1:0]  LP_VC       = 2'(VC);
  localparam logic [5:0]  LP_DT_FS    = 6'h00;
  localparam logic [5:0]  LP_DT_FE    = 6'h01;

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [31:0] hdr_word(input logic [7:0] di, input logic [15:0] field);
    return {2'b00, ecc6({field, di}), field, di};
  endfunction

  // Reflected CCITT: bit 0 of byte 0 enters first.
  function automatic logic [15:0] crc_word(input logic [15:0] crc_in, input logic [63:0] d);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic        r_pv1, r_pv2, r_vs, r_hdr_pend, r_active;
  logic        r_frame_open, r_fe_pend;
  logic [63:0] r_d1, r_d2;
  logic [5:0]  r_dt;
  logic [15:0] r_cnt, r_crc, r_frame_num;
  logic [63:0] r_data;
  logic [7:0]  r_byte_en;
  logic        r_valid, r_sop, r_eop, r_err;

  logic        w_rise, w_drop, w_accept, w_fs, w_vs_fall, w_fe_req;
  logic        w_payload, w_footer, w_fs_take, w_fe_take;
  logic [15:0] w_fnum_nxt;
  logic [63:0] w_data;
  logic [7:0]  w_be;
  logic        w_valid, w_sop, w_eop;
  logic        w_unused_hsync;

  // Line gaps are measured on the delayed pixel_valid, so hsync carries no extra information.
  assign w_unused_hsync = i_hsync;

  assign w_rise     = i_pixel_valid & ~r_pv1;
  assign w_drop     = w_rise & r_pv2;
  assign w_accept   = w_rise & ~r_pv2;
  assign w_fs       = w_accept & ~r_frame_open;
  assign w_vs_fall  = ~i_vsync & r_vs;
  assign w_fe_req   = r_fe_pend | (w_vs_fall & r_frame_open);
  assign w_payload  = r_active & ~r_hdr_pend & r_pv2;
  assign w_footer   = r_active & ~r_hdr_pend & ~r_pv2;
  assign w_fnum_nxt = ((r_frame_num == 16'd0) || (r_frame_num == LP_FNUM_MAX)) ?
                      16'd1 : (r_frame_num + 16'd1);

  // Output slot arbitration: long packet first, then FS, then (possibly deferred) FE.
  always_comb begin
    w_data    = 64'h0;
    w_be      = 8'h00;
    w_valid   = 1'b0;
    w_sop     = 1'b0;
    w_eop     = 1'b0;
    w_fs_take = 1'b0;
    w_fe_take = 1'b0;
    if (r_hdr_pend) begin
      w_data  = {32'h0, hdr_word({LP_VC, r_dt}, LP_WC)};
      w_be    = 8'h0F;
      w_valid = 1'b1;
      w_sop   = 1'b1;
    end else if (w_payload) begin
      w_data  = r_d2;
      w_be    = 8'hFF;
      w_valid = 1'b1;
    end else if (w_footer) begin
      w_data  = {48'h0, r_crc};
      w_be    = 8'h03;
      w_valid = 1'b1;
      w_eop   = 1'b1;
    end else if (w_fs) begin
      w_data    = {32'h0, hdr_word({LP_VC, LP_DT_FS}, w_fnum_nxt)};
      w_be      = 8'h0F;
      w_valid   = 1'b1;
      w_sop     = 1'b1;
      w_eop     = 1'b1;
      w_fs_take = 1'b1;
    end else if (w_fe_req) begin
      w_data    = {32'h0, hdr_word({LP_VC, LP_DT_FE}, r_frame_num)};
      w_be      = 8'h0F;
      w_valid   = 1'b1;
      w_sop     = 1'b1;
      w_eop     = 1'b1;
      w_fe_take = 1'b1;
    end else begin
      w_valid = 1'b0;
    end
  end

  // Delay line, edge detectors and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pv1      <= 1'b0;
      r_pv2      <= 1'b0;
      r_d1       <= 64'h0;
      r_d2       <= 64'h0;
      r_vs       <= 1'b0;
      r_hdr_pend <= 1'b0;
      r_dt       <= 6'h00;
      r_data     <= 64'h0;
      r_byte_en  <= 8'h00;
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_pv1      <= i_pixel_valid;
      r_pv2      <= r_pv1;
      r_d1       <= i_pixel_data;
      r_d2       <= r_d1;
      r_vs       <= i_vsync;
      r_hdr_pend <= w_accept;
      if (w_accept) r_dt <= i_data_type;
      r_data     <= w_data;
      r_byte_en  <= w_be;
      r_valid    <= w_valid;
      r_sop      <= w_sop;
      r_eop      <= w_eop;
      r_err      <= w_drop | (w_footer & (r_cnt != LP_WORDS));
    end
  end

  // Long-packet state: CRC and word count restart with each emitted header.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_crc    <= 16'hFFFF;
      r_cnt    <= 16'd0;
    end else if (r_hdr_pend) begin
      r_active <= 1'b1;
      r_crc    <= 16'hFFFF;
      r_cnt    <= 16'd0;
    end else if (w_payload) begin
      r_crc    <= crc_word(r_crc, r_d2);
      r_cnt    <= r_cnt + 16'd1;
    end else if (w_footer) begin
      r_active <= 1'b0;
    end
  end

  // Frame bookkeeping; an FE that loses its slot waits in r_fe_pend.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_open <= 1'b0;
      r_frame_num  <= 16'd0;
      r_fe_pend    <= 1'b0;
    end else begin
      r_fe_pend <= w_fe_req & ~w_fe_take;
      if (w_fs_take) begin
        r_frame_num  <= w_fnum_nxt;
        r_frame_open <= 1'b1;
      end else if (w_fe_take) begin
        r_frame_open <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_byte_en = r_byte_en;
  assign o_valid   = r_valid;
  assign o_sop     = r_sop;
  assign o_eop     = r_eop;
  assign o_err     = r_err;

endmodule

// File: tb/tb_csi2_packetizer.sv
// Scoreboard bench for csi2_packetizer: stimulus pushes hand-computed packet words,
// a negedge monitor pops and compares every o_valid cycle.
module tb_csi2_packetizer;
  localparam int HACT = 16;
  localparam int FMAX = 3;
  // Hand-computed header words {ECC, field[15:8], field[7:0], DI}.
  localparam logic [31:0] FS1 = 32'h1A000100;
  localparam logic [31:0] FS2 = 32'h1C000200;
  localparam logic [31:0] FS3 = 32'h06000300;
  localparam logic [31:0] FE1 = 32'h1D000101;
  localparam logic [31:0] FE2 = 32'h1B000201;
  localparam logic [31:0] FE3 = 32'h01000301;
  localparam logic [31:0] HDR = 32'h3200201E;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, pv;
  logic [63:0] pd;
  logic [5:0]  dt;
  logic [63:0] o_data;
  logic [7:0]  o_byte_en;
  logic        o_valid, o_sop, o_eop, o_err;

  always #5 clk = ~clk;

  csi2_packetizer #(.HACT(HACT), .VC(0), .FRAME_NUM_MAX(FMAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_hsync(hsync), .i_vsync(vsync),
    .i_pixel_data(pd), .i_pixel_valid(pv), .i_data_type(dt),
    .o_data(o_data), .o_byte_en(o_byte_en), .o_valid(o_valid),
    .o_sop(o_sop), .o_eop(o_eop), .o_err(o_err)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t        exp_q[$];
  string       nm_q[$];
  int          n_vec = 0, n_bad = 0, err_seen = 0, exp_err = 0;
  int          rst_req = 0, rst_done = 0, err_req = 0, err_done = 0;
  bit          fin_req = 1'b0, fin_done = 1'b0;
  logic [63:0] line_w [8];

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // MSB-first CCITT on bit-reversed bytes, result reversed back.
  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] s;
    logic [7:0]  b;
    s = 16'hFFFF;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 8; k++) begin
        b = line_w[w][8*k +: 8];
        s = s ^ {rev8(b), 8'h00};
        for (int j = 0; j < 8; j++) s = s[15] ? ((s << 1) ^ 16'h1021) : (s << 1);
      end
    end
    return {rev8(s[7:0]), rev8(s[15:8])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] be, input logic sop,
                      input logic eop, input string nm);
    exp_t e;
    e.data = d; e.be = be; e.sop = sop; e.eop = eop;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic set_pattern(input int seed);
    for (int i = 0; i < 8; i++)
      line_w[i] = 64'h0706050403020100 + 64'(i) * 64'h0808080808080808 + 64'(seed) * 64'h0001000100010001;
  endtask

  task automatic run_line(input int n, input bit with_fs, input logic [31:0] fs_w, input bit dropped,
                          input bit use_crc, input logic [15:0] crc_given, input string tag);
    if (!dropped) begin
      if (with_fs) push({32'h0, fs_w}, 8'h0F, 1'b1, 1'b1, {tag, "_fs"});
      push({32'h0, HDR}, 8'h0F, 1'b1, 1'b0, {tag, "_hdr"});
      for (int i = 0; i < n; i++) push(line_w[i], 8'hFF, 1'b0, 1'b0, $sformatf("%s_pl%0d", tag, i));
    end
    for (int i = 0; i < n; i++) begin
      pv = 1'b1; pd = line_w[i]; tick();
    end
    pv = 1'b0; pd = 64'h0;
    if (!dropped)
      push({48'h0, (use_crc ? crc_given : crc_model(n))}, 8'h03, 1'b0, 1'b1, {tag, "_crc"});
  endtask

  task automatic fe(input logic [31:0] w, input string tag);
    vsync = 1'b0;
    push({32'h0, w}, 8'h0F, 1'b1, 1'b1, {tag, "_fe"});
    tick();
    vsync = 1'b1;
  endtask

  // Monitor: all comparisons and their counters live here.
  initial begin
    exp_t        e;
    string       nm;
    logic [63:0] m;
    forever begin
      @(negedge clk);
      if (rst_req != rst_done) begin
        n_vec++;
        if (o_valid || o_sop || o_eop || o_err || o_data != 64'h0 || o_byte_en != 8'h00) begin
          n_bad++;
          $display("FAIL reset_state: valid=%b sop=%b eop=%b err=%b data=%h be=%h, required all zero",
                   o_valid, o_sop, o_eop, o_err, o_data, o_byte_en);
        end
        rst_done = rst_req;
      end
      if (!rst) begin
        if (o_err) err_seen++;
        if (o_valid) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_word: data=%h be=%h sop=%b eop=%b, required no output",
                     o_data, o_byte_en, o_sop, o_eop);
          end else begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            for (int b = 0; b < 8; b++) m[8*b +: 8] = e.be[b] ? 8'hFF : 8'h00;
            if (((o_data & m) != (e.data & m)) || o_byte_en != e.be || o_sop != e.sop || o_eop != e.eop) begin
              n_bad++;
              $display("FAIL %s: data=%h be=%h sop=%b eop=%b, required data=%h be=%h sop=%b eop=%b",
                       nm, o_data & m, o_byte_en, o_sop, o_eop, e.data & m, e.be, e.sop, e.eop);
            end
          end
        end else if (o_sop || o_eop) begin
          n_vec++;
          n_bad++;
          $display("FAIL sop_eop_idle: sop=%b eop=%b while o_valid=0, required 0 0", o_sop, o_eop);
        end
        if (err_req != err_done) begin
          n_vec++;
          if (err_seen != exp_err) begin
            n_bad++;
            $display("FAIL err_count: got %0d pulses, required %0d", err_seen, exp_err);
          end
          err_done = err_req;
        end
        if (fin_req && !fin_done) begin
          n_vec++;
          if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected words never appeared, next %s", exp_q.size(), nm_q[0]);
          end
          fin_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; pv = 1'b0; pd = 64'h0; dt = 6'h1E;
    repeat (3) tick();
    rst_req++;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Frame 1: constant grey line, vsync falls on the footer slot so FE is deferred.
    for (int i = 0; i < 8; i++) line_w[i] = 64'h1080108010801080;
    run_line(4, 1'b1, FS1, 1'b0, 1'b0, 16'h0, "f1");
    tick(); tick();
    fe(FE1, "f1");
    repeat (6) tick();
    exp_err = 0; err_req++; tick();

    // Frame 2: 3-word reference CRC vector on a 4-word line -> short-line error.
    line_w[0] = 64'h72F3DCB9020000FF;
    line_w[1] = 64'h7CC275C85AB8D4BB;
    line_w[2] = 64'h010000FFDF05F881;
    run_line(3, 1'b1, FS2, 1'b0, 1'b1, 16'h00F0, "f2");
    repeat (5) tick();
    fe(FE2, "f2");
    repeat (6) tick();
    exp_err = 1; err_req++; tick();

    // Frame 3: second line follows after a 1-cycle gap and is dropped.
    set_pattern(1);
    run_line(4, 1'b1, FS3, 1'b0, 1'b0, 16'h0, "f3a");
    tick();
    set_pattern(2);
    run_line(4, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, "f3b");
    repeat (6) tick();
    fe(FE3, "f3");
    repeat (6) tick();
    exp_err = 2; err_req++; tick();

    // Frame 4: frame number wraps from 3 back to 1.
    set_pattern(3);
    run_line(4, 1'b1, FS1, 1'b0, 1'b0, 16'h0, "f4");
    repeat (5) tick();
    fe(FE1, "f4");
    repeat (6) tick();

    // Frame 5: reset asserted at t+4, after the first payload word.
    set_pattern(4);
    push({32'h0, FS2}, 8'h0F, 1'b1, 1'b1, "f5_fs");
    push({32'h0, HDR}, 8'h0F, 1'b1, 1'b0, "f5_hdr");
    push(line_w[0], 8'hFF, 1'b0, 1'b0, "f5_pl0");
    for (int i = 0; i < 4; i++) begin
      pv = 1'b1; pd = line_w[i]; tick();
    end
    rst = 1'b1; pv = 1'b0; pd = 64'h0;
    rst_req++;
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();

    // Frame 6: clean restart with frame number 1.
    set_pattern(5);
    run_line(4, 1'b1, FS1, 1'b0, 1'b0, 16'h0, "f6");
    repeat (5) tick();
    fe(FE1, "f6");
    repeat (10) tick();
    exp_err = 2; err_req++; tick();

    fin_req = 1'b1;
    for (int i = 0; i < 20 && !fin_done; i++) tick();
    if (!fin_done) begin
      $display("FAIL final_check: monitor did not complete");
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
